// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters
//            (0 = execute stage, 1 = address-generation / multi-cycle
//            sequencer). It accepts one operation at a time, picks a winner
//            round-robin, drives the ALU for one cycle, registers the result
//            and flags, and returns them over a per-requester response
//            handshake. It is the only writer of the architectural NZCV flags.
// Ports    : clk, reset_n          - clock, synchronous active-low reset
//            req_valid/req_ready   - per-requester request handshake
//            req_inst/req_a/req_b  - {req1, req0} instruction and operands
//            rsp_valid/rsp_ready   - per-requester response handshake
//            rsp_out/rsp_nzcv      - registered result and its flags {N,Z,V,C}
//            alu_regA/B, alu_inst  - operands/instruction driven to the ALU
//            alu_out, alu_N/Z/V/C  - ALU result and flags
//            alu_update_CPSR       - ALU says this instruction writes flags
//            alu_ignore_C_flag     - ALU says C is not written
//            cpsr_nzcv             - architectural flags {N,Z,V,C}
//            busy                  - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [63:0]         req_inst,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_out,
  output logic [3:0]          rsp_nzcv,
  output logic [DATA_W-1:0]   alu_regA,
  output logic [DATA_W-1:0]   alu_regB,
  output logic [31:0]         alu_inst,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_N,
  input  logic                alu_Z,
  input  logic                alu_V,
  input  logic                alu_C,
  input  logic                alu_update_CPSR,
  input  logic                alu_ignore_C_flag,
  output logic [3:0]          cpsr_nzcv,
  output logic                busy
);

  // last_grant resets to the requester that must NOT win first, so that the
  // first simultaneous request after reset goes to RESET_PRIO.
  localparam logic C_LAST_GRANT_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic                grant_q,      grant_d;
  logic                last_grant_q, last_grant_d;
  logic [31:0]         inst_q,       inst_d;
  logic [DATA_W-1:0]   a_q,          a_d;
  logic [DATA_W-1:0]   b_q,          b_d;
  logic [DATA_W-1:0]   rsp_out_q,    rsp_out_d;
  logic [3:0]          rsp_nzcv_q,   rsp_nzcv_d;
  logic [3:0]          cpsr_q,       cpsr_d;

  logic                pick;

  // Round-robin pick: a lone requester always wins; on contention the
  // requester that was not granted last time wins.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b11) begin
      pick = ~last_grant_q;
    end else begin
      pick = req_valid[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    inst_d       = inst_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_out_d    = rsp_out_q;
    rsp_nzcv_d   = rsp_nzcv_q;
    cpsr_d       = cpsr_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted: the latch would be
        // discarded by the reset at the same edge anyway.
        if ((req_valid != 2'b00) && reset_n) begin
          req_ready[pick] = 1'b1;
          grant_d         = pick;
          last_grant_d    = pick;
          inst_d          = pick ? req_inst[63:32]          : req_inst[31:0];
          a_d             = pick ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
          b_d             = pick ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
          state_d         = EXEC;
        end
      end

      EXEC: begin
        rsp_out_d  = alu_out;
        rsp_nzcv_d = {alu_N, alu_Z, alu_V, alu_C};
        // Flag-setting instructions always write N, Z and V; C is kept when
        // the ALU reports that this instruction leaves it alone.
        if (alu_update_CPSR) begin
          cpsr_d[3:1] = {alu_N, alu_Z, alu_V};
          if (!alu_ignore_C_flag) begin
            cpsr_d[0] = alu_C;
          end
        end
        state_d = RESP;
      end

      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        // Only the granted requester's ready can retire the response.
        if (rsp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= C_LAST_GRANT_RST;
      inst_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_out_q    <= '0;
      rsp_nzcv_q   <= '0;
      cpsr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      inst_q       <= inst_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_out_q    <= rsp_out_d;
      rsp_nzcv_q   <= rsp_nzcv_d;
      cpsr_q       <= cpsr_d;
    end
  end

  // ALU inputs come only from the latches, so they never follow req_* and
  // stay stable outside EXEC.
  assign alu_inst  = inst_q;
  assign alu_regA  = a_q;
  assign alu_regB  = b_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_nzcv  = rsp_nzcv_q;
  assign cpsr_nzcv = cpsr_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
